// File: rtl/instruction_controller_pkg.sv
// rtl/instruction_controller_pkg.sv - shared encodings for the instruction sequencer
package instruction_controller_pkg;

  localparam int INSTR_W = 16;

  // Opcode / op field values
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation used for a plain register move (0 + shifted B)
  localparam logic [1:0] ALU_ADD = 2'b00;

  // Writeback value select
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_OPERATE, S_WRITE, S_WRITEIMM, S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    INS_MOV_IMM, INS_MOV_REG, INS_ADD, INS_CMP, INS_AND, INS_MVN, INS_ILLEGAL
  } instr_kind_t;

  function automatic logic [INSTR_W-1:0] sext5(input logic [4:0] v);
    return {{(INSTR_W-5){v[4]}}, v};
  endfunction

  function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] v);
    return {{(INSTR_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/instruction_controller_if.sv
// rtl/instruction_controller_if.sv - start handshake and datapath control bundle
interface instruction_controller_if;
  import instruction_controller_pkg::*;

  logic               s;
  logic [INSTR_W-1:0] instr;
  logic               w;
  logic               illegal;
  logic [2:0]         readnum;
  logic [2:0]         writenum;
  logic               write;
  logic [1:0]         vsel;
  logic               loada;
  logic               loadb;
  logic               asel;
  logic               bsel;
  logic               loadc;
  logic               loads;
  logic [1:0]         shift;
  logic [1:0]         ALUop;
  logic [INSTR_W-1:0] sximm5;
  logic [INSTR_W-1:0] sximm8;

  modport master (
    output s, instr,
    input  w, illegal, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, loadc, loads, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, instr,
    output w, illegal, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, loadc, loads, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - field extraction, sign extension and classification of IR
module instruction_decoder
  import instruction_controller_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output logic [2:0]         o_rn,
  output logic [2:0]         o_rd,
  output logic [2:0]         o_rm,
  output logic [1:0]         o_sh,
  output logic [1:0]         o_op,
  output logic [INSTR_W-1:0] o_sximm5,
  output logic [INSTR_W-1:0] o_sximm8,
  output instr_kind_t        o_kind,
  output logic               o_legal
);

  logic [2:0] w_opcode;

  assign w_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm5 = sext5(i_ir[4:0]);
  assign o_sximm8 = sext8(i_ir[7:0]);
  assign o_legal  = (o_kind != INS_ILLEGAL);

  // Map opcode/op pairs onto the supported instruction set; anything else is illegal
  always_comb begin
    o_kind = INS_ILLEGAL;
    if (w_opcode == OPC_MOV) begin
      if (o_op == OP_MOV_IMM)      o_kind = INS_MOV_IMM;
      else if (o_op == OP_MOV_REG) o_kind = INS_MOV_REG;
    end else if (w_opcode == OPC_ALU) begin
      case (o_op)
        OP_ADD:  o_kind = INS_ADD;
        OP_CMP:  o_kind = INS_CMP;
        OP_AND:  o_kind = INS_AND;
        OP_MVN:  o_kind = INS_MVN;
        default: o_kind = INS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/instruction_controller.sv
// rtl/instruction_controller.sv - Moore sequencer driving register file and computation stage
module instruction_controller
  import instruction_controller_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_controller_if.slave   bus
);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_ir;

  logic [2:0]          w_rn, w_rd, w_rm;
  logic [1:0]          w_sh, w_op;
  logic [INSTR_W-1:0]  w_sximm5, w_sximm8;
  instr_kind_t         w_kind;
  logic                w_legal;

  instruction_decoder u_dec (
    .i_ir     (r_ir),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_sh     (w_sh),
    .o_op     (w_op),
    .o_sximm5 (w_sximm5),
    .o_sximm8 (w_sximm8),
    .o_kind   (w_kind),
    .o_legal  (w_legal)
  );

  assign bus.sximm5 = w_sximm5;
  assign bus.sximm8 = w_sximm8;

  // State register; IR only loads on an accepted start in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && bus.s) r_ir <= bus.instr;
    end
  end

  // Next-state and Moore control outputs from state and IR
  always_comb begin
    w_next       = r_state;
    bus.w        = 1'b0;
    bus.illegal  = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.vsel     = VSEL_C;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    case (r_state)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal) w_next = S_ILLEGAL;
        else begin
          case (w_kind)
            INS_MOV_IMM:                w_next = S_WRITEIMM;
            INS_ADD, INS_CMP, INS_AND:  w_next = S_GETA;
            default:                    w_next = S_GETB;
          endcase
        end
      end
      S_GETA: begin
        bus.readnum = w_rn;
        bus.loada   = 1'b1;
        w_next      = S_GETB;
      end
      S_GETB: begin
        bus.readnum = w_rm;
        bus.loadb   = 1'b1;
        w_next      = S_OPERATE;
      end
      S_OPERATE: begin
        // Single-operand forms zero the A input so the ALU passes or inverts B
        bus.shift = w_sh;
        bus.asel  = (w_kind == INS_MOV_REG) || (w_kind == INS_MVN);
        bus.ALUop = (w_kind == INS_MOV_REG) ? ALU_ADD : w_op;
        if (w_kind == INS_CMP) begin
          bus.loads = 1'b1;
          w_next    = S_WAIT;
        end else begin
          bus.loadc = 1'b1;
          w_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.writenum = w_rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
        w_next       = S_WAIT;
      end
      S_WRITEIMM: begin
        bus.writenum = w_rn;
        bus.vsel     = VSEL_IMM8;
        bus.write    = 1'b1;
        w_next       = S_WAIT;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
        w_next      = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// tb/tb_instruction_controller.sv - directed self-checking bench for instruction_controller
module tb_instruction_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  instruction_controller_if bus_if ();

  instruction_controller #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic wv, input logic ill,
                     input logic [2:0] rn, input logic [2:0] wn, input logic wr,
                     input logic [1:0] vs, input logic la, input logic lb,
                     input logic as, input logic bs, input logic lc, input logic ls,
                     input logic [1:0] sh, input logic [1:0] op);
    logic [31:0] got, exp;
    got = {11'd0, bus_if.w, bus_if.illegal, bus_if.readnum, bus_if.writenum, bus_if.write,
           bus_if.vsel, bus_if.loada, bus_if.loadb, bus_if.asel, bus_if.bsel,
           bus_if.loadc, bus_if.loads, bus_if.shift, bus_if.ALUop};
    exp = {11'd0, wv, ill, rn, wn, wr, vs, la, lb, as, bs, lc, ls, sh, op};
    chk(tag, got, exp);
  endtask

  task automatic idle(input string tag, input logic wv);
    ctl(tag, wv, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic accept(input logic [15:0] ins);
    bus_if.s     = 1'b1;
    bus_if.instr = ins;
    step();
    bus_if.s     = 1'b0;
    bus_if.instr = 16'hFFFF;
  endtask

  initial begin
    reset        = 1'b1;
    bus_if.s     = 1'b0;
    bus_if.instr = 16'h0000;
    step();
    step();
    idle("reset_ctl", 1);
    chk("reset_sximm5", bus_if.sximm5, 16'h0000);
    chk("reset_sximm8", bus_if.sximm8, 16'h0000);
    reset = 1'b0;
    step();
    idle("wait_hold", 1);

    // MOV R0,#7
    accept(16'hD007);
    idle("movi0_c1", 0);
    chk("movi0_sximm8", bus_if.sximm8, 16'h0007);
    step(); ctl("movi0_c2", 0, 0, 3'd0, 3'd0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("movi0_c3", 1);

    // MOV R1,#-2
    accept(16'hD1FE);
    chk("movi1_sximm8", bus_if.sximm8, 16'hFFFE);
    step(); ctl("movi1_c2", 0, 0, 3'd0, 3'd1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("movi1_c3", 1);

    // ADD R2,R1,R0 LSL
    accept(16'hA148);
    idle("add_c1", 0);
    chk("add_sximm5", bus_if.sximm5, 16'h0008);
    step(); ctl("add_c2", 0, 0, 3'd1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("add_c3", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("add_c4", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00);
    step(); ctl("add_c5", 0, 0, 3'd0, 3'd2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("add_c6", 1);

    // CMP R0,R1
    accept(16'hA801);
    idle("cmp_c1", 0);
    step(); ctl("cmp_c2", 0, 0, 3'd0, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("cmp_c3", 0, 0, 3'd1, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("cmp_c4", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01);
    step(); idle("cmp_c5", 1);

    // MVN R3,R0
    accept(16'hB860);
    idle("mvn_c1", 0);
    step(); ctl("mvn_c2", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("mvn_c3", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 2'b11);
    step(); ctl("mvn_c4", 0, 0, 3'd0, 3'd3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("mvn_c5", 1);

    // MOV R2,R2,ASR (sh=11), negative imm5
    accept(16'hC05A);
    chk("movr_sximm5", bus_if.sximm5, 16'hFFFA);
    step(); ctl("movr_c2", 0, 0, 3'd2, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("movr_c3", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 2'b11, 2'b00);
    step(); ctl("movr_c4", 0, 0, 3'd0, 3'd2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("movr_c5", 1);

    // AND R1,R2,R3
    accept(16'hB223);
    step(); ctl("and_c2", 0, 0, 3'd2, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("and_c3", 0, 0, 3'd3, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); ctl("and_c4", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10);
    step(); ctl("and_c5", 0, 0, 3'd0, 3'd1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("and_c6", 1);

    // Illegal encodings
    accept(16'h0000);
    idle("ill0_c1", 0);
    step(); ctl("ill0_c2", 0, 1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("ill0_c3", 1);
    accept(16'hC800);
    step(); ctl("ill1_c2", 0, 1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("ill1_c3", 1);
    accept(16'hE000);
    step(); ctl("ill2_c2", 0, 1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("ill2_c3", 1);

    // Back-to-back with s held high; instr changes outside WAIT are ignored
    bus_if.s = 1'b1; bus_if.instr = 16'hD304;
    step();
    bus_if.instr = 16'hD505;
    idle("b2b_c1", 0);
    chk("b2b_hold_ir", bus_if.sximm8, 16'h0004);
    step(); ctl("b2b_c2", 0, 0, 3'd0, 3'd3, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("b2b_c3", 1);
    step();
    bus_if.s = 1'b0;
    idle("b2b_c4", 0);
    chk("b2b_new_ir", bus_if.sximm8, 16'h0005);
    step(); ctl("b2b_c5", 0, 0, 3'd0, 3'd5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step(); idle("b2b_c6", 1);

    // Reset during OPERATE of ADD aborts the write
    accept(16'hA148);
    step(); step(); step();
    ctl("rst_operate", 0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle("rst_after", 1);
    chk("rst_ir_clr", bus_if.sximm8, 16'h0000);
    step();
    idle("rst_after2", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_controller.md
Name: instruction_controller

Overview:
Sequencing FSM for the simple RISC datapath. It latches a 16-bit instruction on a start handshake and decodes it. Over several cycles it drives the register-file read/write selects and loada/loadb. It also drives the computation stage's asel, bsel, shift, ALUop, loadc and loads, plus the writeback value select. It sits directly upstream of the computation stage and owns every one of that stage's control inputs.

Parameters:
DATA_W, 16, datapath and instruction width; only 16 is supported.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; returns FSM to WAIT
s  in  1  start request; sampled only in WAIT
instr  in  16  instruction word; captured into IR when s=1 in WAIT
w  out  1  idle/ready; 1 only in WAIT
illegal  out  1  one-cycle pulse on an unsupported opcode/op
readnum  out  3  register-file read index
writenum  out  3  register-file write index
write  out  1  register-file write enable
vsel  out  2  writeback select: 00=C, 01=sximm8
loada, loadb  out  1 each  A/B pipeline register enables
asel, bsel  out  1 each  computation-stage operand selects (asel=1 forces Ain=0; bsel=1 selects sximm5)
loadc, loads  out  1 each  C and status register enables
shift  out  2  IR[4:3]
ALUop  out  2  ALU operation
sximm5  out  16  sign-extended IR[4:0]
sximm8  out  16  sign-extended IR[7:0]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: on a rising edge with reset=1 the state becomes WAIT and IR is cleared to 0. Reset has priority over s.
- Instruction fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Outputs are Moore: they are functions of state and IR only. Every enable, write, illegal and select defaults to 0. readnum, writenum, vsel and ALUop default to 0.
- Reset values: w=1; all enables, write and illegal are 0; sximm5 and sximm8 are 0 (IR=0).
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD
  - 101/01: CMP
  - 101/10: AND
  - 101/11: MVN
  - Every other opcode/op combination is illegal.
- WAIT: w=1. If s=1, IR<=instr and the next state is DECODE. Otherwise the state stays WAIT. s in any other state is ignored, and instr is ignored outside an accept.
- DECODE: all controls idle. Next state:
  - MOV imm -> WRITEIMM
  - ADD, CMP, AND -> GETA
  - MOV reg, MVN -> GETB
  - illegal -> ILLEGAL
- GETA: readnum=Rn, loada=1. Next state GETB.
- GETB: readnum=Rm, loadb=1. Next state OPERATE.
- OPERATE: bsel=0 and shift=sh.
  - asel=1 for MOV reg and MVN; otherwise asel=0.
  - ALUop=00 for MOV reg; otherwise ALUop=op.
  - CMP: loads=1, loadc=0, next state WAIT.
  - All others: loadc=1, loads=0, next state WRITE.
- WRITE: writenum=Rd, vsel=00, write=1. Next state WAIT.
- WRITEIMM: writenum=Rn, vsel=01, write=1. Next state WAIT.
- ILLEGAL: illegal=1 for exactly one cycle, no other control asserted. Next state WAIT.
- Latency, counted in cycles after the accept edge until w=1:
  - MOV imm: 3
  - ADD/AND: 6
  - CMP: 5
  - MOV reg/MVN: 5
  - illegal: 3
- Pulse widths: write, loada, loadb, loadc and loads are each high for at most one cycle per instruction.
- Back-to-back: s held high in WAIT accepts a new instruction on the same edge that leaves WAIT. No bubble is required beyond the single WAIT cycle.
- Reset mid-operation: reset in any state aborts the instruction. No write, loadc or loads occurs on the cycle after reset.

Decomposition:
- Shared package: opcode/op constants, state encoding (WAIT, DECODE, GETA, GETB, OPERATE, WRITE, WRITEIMM, ILLEGAL), vsel encodings (VSEL_C, VSEL_IMM8), ALUop constants.
- Sub-module instruction_decoder: combinational field extraction and sign extension from IR (fields, sximm5, sximm8, legal flag).

Test Plan:
1. Reset, then s=1 with instr=0xD007 (MOV R0,#7) -> WRITEIMM in the 2nd cycle after accept with writenum=0, vsel=01, sximm8=0x0007 and write=1 for one cycle; w=1 at cycle 3.
2. instr=0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE; write pulse with writenum=1.
3. instr=0xA148 (ADD R2,R1,R0 LSL) -> the controls appear cycle by cycle:
   - cycle 2: readnum=1, loada=1
   - cycle 3: readnum=0, loadb=1
   - cycle 4: asel=0, bsel=0, shift=01, ALUop=00, loadc=1
   - cycle 5: writenum=2, write=1
   - cycle 6: w=1
4. instr=0xA801 (CMP R0,R1) -> the OPERATE cycle has ALUop=01, loads=1, loadc=0; write never asserts; w=1 at cycle 5.
5. instr=0xB860 (MVN R3,R0) -> loada is never asserted; OPERATE has asel=1, ALUop=11, loadc=1; then write with writenum=3.
6. instr=0x0000 -> illegal=1 for one cycle, no enables, w=1 at cycle 3. Separately, assert reset during OPERATE of 0xA148 -> next cycle is WAIT with w=1; write and loadc remain 0.
